// File: rtl/regtmp_retire.sv
// Retire stage for the temp register ring: in-order commit, branch flush.
// Define COMMIT_COUNT_EN to build the retired-entry counter.
module regtmp_retire (
  input  logic        clock,
  input  logic        reset,
  input  logic        New_entry,
  output logic [4:0]  Waddr_out,
  output logic [4:0]  Rd_Addr,
  input  logic [41:0] Data_In,
  input  logic        Stall,
  output logic        Commit_en,
  output logic [4:0]  Commit_rd,
  output logic [31:0] Commit_PC,
  output logic        Clear_entry,
  output logic [4:0]  Clear_addr,
  output logic        Flush,
  output logic [31:0] Flush_PC,
  output logic        Full,
  output logic        Empty,
  output logic [15:0] Commit_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_FLUSH
  } state_t;

  state_t      state;
  logic [4:0]  head;
  logic [4:0]  tail;
  logic [5:0]  count;
  logic [5:0]  count_nxt;
  logic        eligible;
  logic        is_br;
  logic        alloc;
  logic        drain;
  logic        pop;

  assign Full      = (count == 6'd32);
  assign Empty     = (count == 6'd0);
  assign Waddr_out = tail;
  assign Rd_Addr   = head;

  assign eligible = (state == S_ACTIVE) && Data_In[0]
                    && Data_In[1] && !Stall;
  assign is_br = (Data_In[4:3] == 2'b11) && Data_In[2];
  assign alloc = New_entry && !Full && (state != S_FLUSH);
  assign drain = (state == S_FLUSH) && (count != 6'd0);
  assign pop   = eligible || drain;

  always_comb begin
    count_nxt = count;
    if (alloc && !pop)
      count_nxt = count + 6'd1;
    else if (!alloc && pop)
      count_nxt = count - 6'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      Commit_en   <= 1'b0;
      Commit_rd   <= '0;
      Commit_PC   <= '0;
      Clear_entry <= 1'b0;
      Clear_addr  <= '0;
      Flush       <= 1'b0;
      Flush_PC    <= '0;
    end else begin
      Commit_en   <= 1'b0;
      Clear_entry <= 1'b0;
      Flush       <= 1'b0;
      count       <= count_nxt;
      if (alloc)
        tail <= tail + 5'd1;
      if (pop) begin
        head        <= head + 5'd1;
        Clear_entry <= 1'b1;
        Clear_addr  <= head;
      end
      case (state)
        S_IDLE: begin
          if (count_nxt != 6'd0)
            state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (eligible) begin
            Commit_en <= 1'b1;
            Commit_rd <= Data_In[41:37];
            Commit_PC <= Data_In[36:5];
            if (is_br) begin
              Flush    <= 1'b1;
              Flush_PC <= Data_In[36:5];
              // a mispredict on the last entry has nothing left to drain
              state    <= (count_nxt != 6'd0) ? S_FLUSH : S_IDLE;
            end else if (count_nxt == 6'd0) begin
              state <= S_IDLE;
            end
          end
        end
        S_FLUSH: begin
          if (count_nxt == 6'd0)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef COMMIT_COUNT_EN
  logic [15:0] commit_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      commit_cnt <= '0;
    else if (eligible)
      commit_cnt <= commit_cnt + 16'd1;
  end

  assign Commit_count = commit_cnt;
`else
  assign Commit_count = 16'h0000;
`endif

endmodule

// File: doc/regtmp_retire.md
REGTMP_RETIRE -- requirements
Module: regtmp_retire

Interface
REQ-001 clock  input  1  sole clock; all state updates on the rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; the block is in reset while reset=0.
REQ-003 New_entry  input  1  allocator wrote an entry at Waddr_out this cycle.
REQ-004 Waddr_out  output  5  tail pointer; the next entry slot the allocator writes.
REQ-005 Rd_Addr  output  5  head pointer, driven to the temp register file read port.
REQ-006 Data_In  input  42  combinational read data for Rd_Addr: [41:37] rd_reg, [36:5] PC, [4:3] Inst_type, [2] spec_data, [1] spec_valid, [0] valid.
REQ-007 Stall  input  1  architectural register file cannot accept a commit this cycle.
REQ-008 Commit_en, Commit_rd[4:0], Commit_PC[31:0]  output  retire strobe, destination register and PC of the retired entry.
REQ-009 Clear_entry, Clear_addr[4:0]  output  invalidate strobe and slot for the temp register file.
REQ-010 Flush, Flush_PC[31:0]  output  mispredict strobe and PC of the offending branch.
REQ-011 Full, Empty  output  1 each  occupancy flags.
REQ-012 Commit_count  output  16  count of retired entries (see Configuration).

Function
REQ-013 Head, tail and count are internal; count is 6 bits, 0..32; the 32-entry ring wraps 31->0 for both head and tail.
REQ-014 Full=(count==32); Empty=(count==0); both outputs are combinational from count.
REQ-015 FSM states: IDLE (count==0), ACTIVE, FLUSH.
REQ-016 IDLE->ACTIVE on the edge at which count becomes nonzero.
REQ-017 In ACTIVE, the head entry is eligible when Data_In[0]=1, Data_In[1]=1 and Stall=0.
REQ-018 On eligibility, at the next edge the block drives Commit_en=1 for one cycle with Commit_rd=Data_In[41:37] and Commit_PC=Data_In[36:5], drives Clear_entry=1 with Clear_addr=old head, increments head and decrements count.
REQ-019 Retirement sustains one entry per cycle back-to-back; Rd_Addr always equals the current head.
REQ-020 A non-eligible head holds all state and keeps all strobes at 0.
REQ-021 An eligible entry with Inst_type=2'b11 and spec_data=1 retires per REQ-018 and, in the same cycle, drives Flush=1 with Flush_PC=entry PC; the state moves to FLUSH.
REQ-022 In FLUSH, each cycle clears the head slot (Clear_entry=1, Clear_addr=head) and then increments head and decrements count, regardless of valid or Stall; Commit_en stays 0.
REQ-023 FLUSH exits to IDLE on the edge at which count reaches 0; the tail is unchanged, so head equals tail afterwards.
REQ-024 New_entry increments tail and count, except that it is ignored while Full=1 or the state is FLUSH.
REQ-025 A simultaneous New_entry and retire leaves count unchanged while both head and tail advance.
REQ-026 ACTIVE->IDLE occurs when a retire brings count to 0 with no simultaneous New_entry.

Reset
REQ-027 While reset=0, all of the following hold: head=tail=count=0, state=IDLE, Commit_en=Clear_entry=Flush=0, Commit_rd=Clear_addr=0, Commit_PC=Flush_PC=0, Commit_count=0, Empty=1, Full=0.
REQ-028 Reset asserted mid-FLUSH or mid-retire aborts the operation immediately, and no strobe is issued after reset releases.

Configuration
REQ-029 With COMMIT_COUNT_EN defined, Commit_count increments by 1 on every Commit_en pulse and wraps at 16'hFFFF->0.
REQ-030 With COMMIT_COUNT_EN undefined, no counter is built and Commit_count is tied to 16'h0000.

Verification
REQ-031 Bench: 3 New_entry pulses with each entry returned valid=1 and spec_valid=1 -> Commit_en pulses on 3 consecutive cycles with Clear_addr 0,1,2, then Empty=1.
REQ-032 Bench: 32 allocations followed by a 33rd -> Full=1, the 33rd is ignored, and Waddr_out=0 (wrapped).
REQ-033 Bench: head entry has spec_valid=0 for 4 cycles, then 1, with Stall=1 for one further cycle -> no Commit_en until the cycle after Stall=0.
REQ-034 Bench: 5 entries with entry 1 = {Inst_type=11, spec_data=1, PC=32'h80000001} -> entry 0 commits, entry 1 commits with Flush=1 and Flush_PC=32'h80000001, 3 clear-only cycles follow, then IDLE.
REQ-035 Bench: reset=0 asserted during FLUSH -> all outputs 0 and Empty=1 while reset=0, and no Clear_entry after release.
REQ-036 Bench: build with COMMIT_COUNT_EN and retire 10 entries -> Commit_count=10; build without it -> Commit_count=0.
